// File: rtl/whack_pkg.sv
// Shared types, default game constants and helpers for the whack-a-mole scorer.
package whack_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        OVER  = 2'd2
    } state_t;

    localparam int unsigned DEF_N_MOLES    = 8;
    localparam int unsigned DEF_SCORE_W    = 8;
    localparam int unsigned DEF_MAX_MISSES = 15;
    localparam int unsigned DEF_LEVEL_BASE = 20;
    localparam int unsigned DEF_LEVEL_STEP = 10;
    localparam int unsigned DEF_MAX_LEVEL  = 7;

    // Widest mole vector the popcount helper accepts.
    localparam int unsigned POP_MAX_W = 32;
    localparam int unsigned LEVEL_CAP = 7;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < POP_MAX_W; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    // Threshold chain: highest level whose score threshold has been reached.
    function automatic logic [2:0] level_of(input int unsigned s,
                                            input int unsigned base,
                                            input int unsigned step,
                                            input int unsigned max_lvl);
        logic [2:0] lvl;
        lvl = 3'd1;
        for (int unsigned i = 2; i <= LEVEL_CAP; i++) begin
            if (i <= max_lvl && s >= base + (i - 2) * step) begin
                lvl = 3'(i);
            end
        end
        return lvl;
    endfunction

endpackage

// File: rtl/sw_toggle_sync.sv
// Three-flop switch synchroniser; flags a level change seen between the last two stages.
module sw_toggle_sync #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sw,
    output logic [W-1:0] toggle_c
);

    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign toggle_c = s2 ^ s3;

endmodule

// File: rtl/whack_hit_scorer.sv
// Game-logic stage: tracks lit moles, scores switch hits, counts misses and derives the speed level.
module whack_hit_scorer
    import whack_pkg::*;
#(
    parameter int unsigned N_MOLES    = DEF_N_MOLES,
    parameter int unsigned SCORE_W    = DEF_SCORE_W,
    parameter int unsigned MAX_MISSES = DEF_MAX_MISSES,
    parameter int unsigned LEVEL_BASE = DEF_LEVEL_BASE,
    parameter int unsigned LEVEL_STEP = DEF_LEVEL_STEP,
    parameter int unsigned MAX_LEVEL  = DEF_MAX_LEVEL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [N_MOLES-1:0] mole,
    input  logic [N_MOLES-1:0] sw,
    output logic [N_MOLES-1:0] mole_led,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         level,
    output logic [3:0]         misses,
    output logic               hit_pulse,
    output logic               game_over
);

    localparam int unsigned CNT_W    = $clog2(N_MOLES + 1);
    localparam int unsigned SUM_W    = ((SCORE_W > CNT_W) ? SCORE_W : CNT_W) + 1;
    localparam int unsigned MISS_W   = 4;
    localparam int unsigned MSUM_W   = ((MISS_W > CNT_W) ? MISS_W : CNT_W) + 1;

    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [MISS_W-1:0]  MISS_LIMIT = MISS_W'(MAX_MISSES);

    state_t state_q;
    state_t state_d;

    logic [N_MOLES-1:0] toggle_c;
    logic [N_MOLES-1:0] hits;
    logic [N_MOLES-1:0] left;
    logic [CNT_W-1:0]   hit_cnt;
    logic [CNT_W-1:0]   left_cnt;
    logic [SUM_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;
    logic [MSUM_W-1:0]  miss_sum;
    logic [MISS_W-1:0]  miss_sat;

    logic [N_MOLES-1:0] led_d;
    logic [SCORE_W-1:0] score_d;
    logic [2:0]         level_d;
    logic [MISS_W-1:0]  misses_d;
    logic               hit_d;
    logic               over_d;

    sw_toggle_sync #(
        .W (N_MOLES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .toggle_c (toggle_c)
    );

    // Hit and miss arithmetic, both clamped instead of wrapping.
    always_comb begin
        hits      = toggle_c & mole_led;
        left      = mole_led & ~hits;
        hit_cnt   = CNT_W'(popcount(POP_MAX_W'(hits)));
        left_cnt  = CNT_W'(popcount(POP_MAX_W'(left)));
        score_sum = SUM_W'(score) + SUM_W'(hit_cnt);
        score_sat = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
        miss_sum  = MSUM_W'(misses) + MSUM_W'(left_cnt);
        miss_sat  = (miss_sum > MSUM_W'(MISS_LIMIT)) ? MISS_LIMIT : miss_sum[MISS_W-1:0];
    end

    always_comb begin
        level_d = level_of(32'(score), LEVEL_BASE, LEVEL_STEP, MAX_LEVEL);
    end

    // Next-state and next-value logic for the round FSM.
    always_comb begin
        state_d  = state_q;
        led_d    = mole_led;
        score_d  = score;
        misses_d = misses;
        hit_d    = 1'b0;
        over_d   = game_over;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    led_d   = mole;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (hits != '0) begin
                    led_d   = left;
                    score_d = score_sat;
                    hit_d   = 1'b1;
                end
                if (tick) begin
                    misses_d = miss_sat;
                    if (miss_sat >= MISS_LIMIT) begin
                        state_d = OVER;
                        led_d   = '0;
                        over_d  = 1'b1;
                    end else begin
                        led_d = mole;
                    end
                end
            end
            OVER: begin
                led_d  = '0;
                over_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                led_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mole_led  <= '0;
            score     <= '0;
            level     <= 3'd1;
            misses    <= '0;
            hit_pulse <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state_q   <= state_d;
            mole_led  <= led_d;
            score     <= score_d;
            level     <= level_d;
            misses    <= misses_d;
            hit_pulse <= hit_d;
            game_over <= over_d;
        end
    end

endmodule

// File: tb/tb_whack_hit_scorer.sv
// Directed bench for whack_hit_scorer with a cycle-level behavioural game model.
module tb_whack_hit_scorer;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [7:0] mole;
    logic [7:0] sw;
    logic [7:0] mole_led;
    logic [7:0] score;
    logic [2:0] level;
    logic [3:0] misses;
    logic       hit_pulse;
    logic       game_over;

    int n_vec;
    int n_miss;

    // Game model state
    logic [7:0] m_led;
    int         m_score;
    int         m_misses;
    int         m_level;
    bit         m_hit;
    bit         m_over;
    bit         m_started;
    logic [7:0] sw_seen [3];

    whack_hit_scorer dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .mole      (mole),
        .sw        (sw),
        .mole_led  (mole_led),
        .score     (score),
        .level     (level),
        .misses    (misses),
        .hit_pulse (hit_pulse),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lvl_of(input int s);
        int l;
        if (s < 20) return 1;
        l = 2 + (s - 20) / 10;
        return (l > 7) ? 7 : l;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_led     = 8'h00;
        m_score   = 0;
        m_misses  = 0;
        m_level   = 1;
        m_hit     = 1'b0;
        m_over    = 1'b0;
        m_started = 1'b0;
        for (int i = 0; i < 3; i++) sw_seen[i] = 8'h00;
    endtask

    // The game sees each switch two samples late; a change in that late view is a whack.
    task automatic model_step();
        logic [7:0] tog;
        logic [7:0] hits;
        if (rst) begin
            model_reset();
            return;
        end
        tog = sw_seen[1] ^ sw_seen[2];
        sw_seen[2] = sw_seen[1];
        sw_seen[1] = sw_seen[0];
        sw_seen[0] = sw;
        m_level = lvl_of(m_score);
        m_hit = 1'b0;
        if (m_over) begin
            m_led = 8'h00;
        end else if (!m_started) begin
            if (tick) begin
                m_led = mole;
                m_started = 1'b1;
            end
        end else begin
            hits = tog & m_led;
            if (hits != 8'h00) begin
                m_score = m_score + $countones(hits);
                if (m_score > 255) m_score = 255;
                m_hit = 1'b1;
                m_led = m_led & ~hits;
            end
            if (tick) begin
                m_misses = m_misses + $countones(m_led);
                if (m_misses > 15) m_misses = 15;
                if (m_misses >= 15) begin
                    m_over = 1'b1;
                    m_led = 8'h00;
                end else begin
                    m_led = mole;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("mole_led",  32'(mole_led),  32'(m_led));
        chk("score",     32'(score),     32'(m_score));
        chk("level",     32'(level),     32'(m_level));
        chk("misses",    32'(misses),    32'(m_misses));
        chk("hit_pulse", 32'(hit_pulse), 32'(m_hit));
        chk("game_over", 32'(game_over), 32'(m_over));
    endtask

    // One clock: model follows the edge, outputs compared just after it; returns at the negedge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_tick(input logic [7:0] m);
        tick = 1'b1;
        mole = m;
        cyc();
        tick = 1'b0;
        mole = 8'h00;
    endtask

    task automatic flip(input logic [7:0] mask);
        sw = sw ^ mask;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        model_reset();
        rst  = 1'b1;
        tick = 1'b0;
        mole = 8'h00;
        sw   = 8'h00;
        @(negedge clk);
        cycn(2);
        chk("rst_level", 32'(level), 32'd1);
        chk("rst_led", 32'(mole_led), 32'h0);
        rst = 1'b0;
        cycn(2);

        // First round and a single hit three edges after the switch flips
        do_tick(8'hA5);
        chk("start_led", 32'(mole_led), 32'hA5);
        flip(8'h01);
        cycn(3);
        chk("hit1_score", 32'(score), 32'd1);
        chk("hit1_led", 32'(mole_led), 32'hA4);
        chk("hit1_pulse", 32'(hit_pulse), 32'd1);
        cyc();
        chk("hit1_pulse_end", 32'(hit_pulse), 32'd0);

        // Unlit and already-whacked switches score nothing
        flip(8'h02);
        cycn(4);
        chk("unlit_score", 32'(score), 32'd1);
        flip(8'h01);
        cycn(4);
        chk("rewhack_score", 32'(score), 32'd1);
        chk("rewhack_led", 32'(mole_led), 32'hA4);

        // Two hits on one edge
        flip(8'hA0);
        cycn(3);
        chk("dbl_score", 32'(score), 32'd3);
        chk("dbl_led", 32'(mole_led), 32'h04);
        cyc();

        // Hit on the same cycle as the round-ending tick
        do_tick(8'h81);
        chk("tick1_misses", 32'(misses), 32'd1);
        flip(8'h01);
        cycn(2);
        do_tick(8'h81);
        chk("same_score", 32'(score), 32'd4);
        chk("same_misses", 32'(misses), 32'd2);
        chk("same_led", 32'(mole_led), 32'h81);

        // Climb to the level-2 threshold
        flip(8'h81);
        cycn(4);
        do_tick(8'hFF);
        flip(8'hFF);
        cycn(4);
        do_tick(8'h1F);
        flip(8'h1F);
        cycn(4);
        chk("s19_score", 32'(score), 32'd19);
        chk("s19_level", 32'(level), 32'd1);
        do_tick(8'h01);
        flip(8'h01);
        cycn(3);
        chk("s20_score", 32'(score), 32'd20);
        chk("s20_level_lag", 32'(level), 32'd1);
        cyc();
        chk("s20_level", 32'(level), 32'd2);

        // Saturate the score
        for (int r = 0; r < 30; r++) begin
            do_tick(8'hFF);
            flip(8'hFF);
            cycn(4);
        end
        chk("sat_score", 32'(score), 32'd255);
        chk("sat_level", 32'(level), 32'd7);

        // Empty patterns neither score nor miss
        do_tick(8'h00);
        do_tick(8'h00);
        chk("empty_misses", 32'(misses), 32'd2);

        // Leave one mole lit each round until the game ends
        do_tick(8'h01);
        for (int r = 0; r < 13; r++) do_tick(8'h01);
        chk("over_misses", 32'(misses), 32'd15);
        chk("over_flag", 32'(game_over), 32'd1);
        chk("over_led", 32'(mole_led), 32'h0);
        do_tick(8'hFF);
        flip(8'hFF);
        cycn(5);
        chk("frozen_score", 32'(score), 32'd255);
        chk("frozen_misses", 32'(misses), 32'd15);
        chk("frozen_led", 32'(mole_led), 32'h0);
        chk("frozen_level", 32'(level), 32'd7);

        // Asynchronous reset in the middle of a round with a toggle in flight
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cycn(4);
        do_tick(8'hA5);
        flip(8'h01);
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("arst_led", 32'(mole_led), 32'h0);
        chk("arst_score", 32'(score), 32'd0);
        chk("arst_level", 32'(level), 32'd1);
        chk("arst_misses", 32'(misses), 32'd0);
        chk("arst_pulse", 32'(hit_pulse), 32'd0);
        chk("arst_over", 32'(game_over), 32'd0);
        model_reset();
        cycn(2);
        rst = 1'b0;
        cycn(6);
        chk("post_score", 32'(score), 32'd0);
        chk("post_led", 32'(mole_led), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/whack_hit_scorer.md
Name: whack_hit_scorer

Overview:
- Game-logic stage between the mole pattern generator (LFSR, advanced by the game tick) and the BCD/7-segment display path.
- Holds the current round's lit-mole pattern and synchronises the raw switches; a switch toggle on a lit mole is a hit.
- Accumulates a saturating score, tracks missed moles, and derives the speed level that selects the game tick rate.
- Enters game-over when misses reach a limit.

Parameters:
- N_MOLES, 8, number of mole LEDs/switches.
- SCORE_W, 8, score width; score saturates at 2^SCORE_W-1.
- MAX_MISSES, 15, miss count that ends the game.
- LEVEL_BASE, 20, score at which level 2 begins.
- LEVEL_STEP, 10, score increment per further level.
- MAX_LEVEL, 7, highest level.

Ports:
- clk, in, 1, system clock; all logic on its rising edge.
- rst, in, 1, asynchronous active-high reset.
- tick, in, 1, one-clk game-round strobe (already in clk domain).
- mole, in, N_MOLES, new pattern; sampled only when tick=1.
- sw, in, N_MOLES, raw asynchronous switch levels.
- mole_led, out, N_MOLES, currently lit, not-yet-whacked moles.
- score, out, SCORE_W, accumulated hits.
- level, out, 3, speed level, 1..MAX_LEVEL.
- misses, out, 4, lit moles left unwhacked at round ends; saturates at MAX_MISSES.
- hit_pulse, out, 1, one-clk pulse on any scoring cycle.
- game_over, out, 1, high in OVER state.

Behaviour:
- Reset (async, rst=1) values:
  - mole_led=0, score=0, level=1, misses=0, hit_pulse=0, game_over=0.
  - Synchroniser flops=0; state=IDLE.
- Switch path:
  - Three flops per bit: s1<=sw, s2<=s1, s3<=s2.
  - toggle = s2^s3.
  - A sw change before edge e1 updates score/mole_led at edge e3.
- States:
  - IDLE: toggles discarded. On tick, mole_led<=mole, go to ROUND.
  - ROUND: per cycle, hits = toggle & mole_led.
    - If hits!=0: mole_led<=mole_led & ~hits; score<=sat(score+popcount(hits)); hit_pulse=1.
    - Toggles on unlit bits are ignored; no penalty.
  - ROUND on tick:
    - Hits in that same cycle are scored first.
    - misses<=sat(misses+popcount(mole_led & ~hits)).
    - mole_led<=mole (new pattern); a bit whacked in the old pattern does not clear the same bit of the new one.
    - If the updated miss count is >= MAX_MISSES, go to OVER instead and clear mole_led.
  - OVER: mole_led=0, game_over=1. score, misses and level are frozen; tick and toggles are ignored. Only rst exits.
- Arithmetic:
  - Add up to N_MOLES in one cycle.
  - score clamps at all-ones and never wraps.
  - misses clamps at MAX_MISSES.
- Level:
  - Registered; updates one clk after score.
  - level = 1 if score<LEVEL_BASE, else min(MAX_LEVEL, 2+(score-LEVEL_BASE)/LEVEL_STEP).
  - Implemented as a threshold compare chain, no divider.
- Empty pattern: tick with mole=0 is legal; that round cannot miss or score.
- Reset mid-round: everything returns to reset values immediately; a pending toggle is lost.

Decomposition:
- Package whack_pkg holds:
  - The state enum {IDLE, ROUND, OVER}.
  - Default constants for MAX_MISSES, LEVEL_BASE, LEVEL_STEP, MAX_LEVEL.
  - A popcount function over N_MOLES bits.
- One sub-module, sw_toggle_sync: N_MOLES-wide 3-flop synchroniser plus toggle output, with clk/rst matching this block.

Test Plan:
- Reset then tick with mole=8'hA5 -> mole_led=8'hA5, state ROUND. Flip sw[0] -> 3 edges later score=1, mole_led=8'hA4, hit_pulse one cycle.
- Flip sw[1] (unlit) -> score unchanged, no hit_pulse. Flip sw[0] again after it is whacked -> no score.
- sw[7] and sw[5] flipped on the same edge with mole_led=8'hA4 -> score +2 in one cycle, mole_led=8'h04.
- Hit landing on the same cycle as tick, old=8'h81, hit bit0, new mole=8'h81 -> score+1, misses+1, mole_led=8'h81.
- Preload score to 19 then 1 hit -> score=20, level=2 one clk later. Drive score to 255 -> stays 255, level=7.
- Fifteen ticks each leaving one lit mole -> misses=15, game_over=1, mole_led=0; further ticks and toggles change nothing. rst asserted asynchronously mid-round -> all outputs at reset values without a clock edge.
